// File: rtl/run_ctrl_pkg.sv
// Shared state and halt-cause encodings for the debug run-state controller.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_RUN_N = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    CAUSE_NONE    = 3'd0,
    CAUSE_SYSCALL = 3'd1,
    CAUSE_BREAK   = 3'd2,
    CAUSE_STEP    = 3'd3,
    CAUSE_COUNT   = 3'd4,
    CAUSE_PAUSE   = 3'd5
  } cause_e;

  localparam int NCYC_W = 16;

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchroniser for an asynchronous debounced button followed by a
// rising-edge detector; a held button yields a single one-cycle pulse.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic pulse_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Pulse is visible the cycle after the second sync flop rises.
  assign pulse_o = sync2_q & ~prev_q;

endmodule

// File: rtl/run_ctrl.sv
// Debug run-state controller: sequences RUN/HALT/STEP/RUN_N, drives the
// pipeline-wide enable and records why the pipeline last halted.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int PC_W      = 32,
  parameter int CNT_W     = 32,
  parameter bit START_RUN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              step,
  input  logic              pause,
  input  logic              run_n,
  input  logic [NCYC_W-1:0] n_cycles,
  input  logic              halt_req,
  input  logic              bp_en,
  input  logic [PC_W-1:0]   bp_addr,
  input  logic [PC_W-1:0]   pc,
  output logic              cpu_en,
  output logic              halted,
  output logic [2:0]        cause,
  output logic [CNT_W-1:0]  cycle_cnt
);

  logic go_p, step_p, pause_p, run_n_p;

  btn_edge u_go    (.clk(clk), .rst(rst), .btn_i(go),    .pulse_o(go_p));
  btn_edge u_step  (.clk(clk), .rst(rst), .btn_i(step),  .pulse_o(step_p));
  btn_edge u_pause (.clk(clk), .rst(rst), .btn_i(pause), .pulse_o(pause_p));
  btn_edge u_run_n (.clk(clk), .rst(rst), .btn_i(run_n), .pulse_o(run_n_p));

  state_e             state_q, state_d;
  cause_e             cause_q, cause_d;
  logic [NCYC_W-1:0]  cnt_q, cnt_d;
  logic               mask_q, mask_d;
  logic               bp_hold_q, bp_hold_d;
  logic               cpu_en_q, halted_q;
  logic [CNT_W-1:0]   cycle_cnt_q;
  logic               pc_match_s;
  logic               halt_sys_s;
  logic               halt_bp_s;

  assign pc_match_s = bp_en && (pc == bp_addr);
  assign halt_sys_s = !mask_q && halt_req;
  assign halt_bp_s  = !mask_q && pc_match_s && !bp_hold_q;

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    cnt_d     = cnt_q;
    mask_d    = mask_q;
    bp_hold_d = bp_hold_q;
    case (state_q)
      ST_HALT: begin
        if (go_p) begin
          state_d   = ST_RUN;
          mask_d    = 1'b1;
          bp_hold_d = 1'b0;
        end else if (step_p) begin
          state_d   = ST_STEP;
          mask_d    = 1'b1;
          bp_hold_d = 1'b0;
        end else if (run_n_p && (n_cycles != {NCYC_W{1'b0}})) begin
          state_d   = ST_RUN_N;
          cnt_d     = n_cycles;
          mask_d    = 1'b1;
          bp_hold_d = 1'b0;
        end else begin
          state_d = ST_HALT;
        end
      end
      ST_RUN, ST_STEP, ST_RUN_N: begin
        mask_d = 1'b0;
        // A breakpoint PC swallowed by the resume mask stays ignored until the next resume.
        if (mask_q && pc_match_s) begin
          bp_hold_d = 1'b1;
        end else begin
          bp_hold_d = bp_hold_q;
        end
        if (halt_sys_s) begin
          state_d = ST_HALT;
          cause_d = CAUSE_SYSCALL;
          cnt_d   = {NCYC_W{1'b0}};
        end else if (halt_bp_s) begin
          state_d = ST_HALT;
          cause_d = CAUSE_BREAK;
          cnt_d   = {NCYC_W{1'b0}};
        end else if (pause_p) begin
          state_d = ST_HALT;
          cause_d = CAUSE_PAUSE;
          cnt_d   = {NCYC_W{1'b0}};
        end else if (state_q == ST_STEP) begin
          state_d = ST_HALT;
          cause_d = CAUSE_STEP;
        end else if (state_q == ST_RUN_N) begin
          if (cnt_q == {{(NCYC_W-1){1'b0}}, 1'b1}) begin
            state_d = ST_HALT;
            cause_d = CAUSE_COUNT;
            cnt_d   = {NCYC_W{1'b0}};
          end else begin
            cnt_d = cnt_q - {{(NCYC_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= START_RUN ? ST_RUN : ST_HALT;
      cpu_en_q    <= START_RUN;
      halted_q    <= !START_RUN;
      cause_q     <= CAUSE_NONE;
      cnt_q       <= {NCYC_W{1'b0}};
      mask_q      <= 1'b0;
      bp_hold_q   <= 1'b0;
      cycle_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      cpu_en_q  <= (state_d != ST_HALT);
      halted_q  <= (state_d == ST_HALT);
      cause_q   <= cause_d;
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      bp_hold_q <= bp_hold_d;
      if (cpu_en_q) begin
        cycle_cnt_q <= cycle_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cycle_cnt_q <= cycle_cnt_q;
      end
    end
  end

  assign cpu_en    = cpu_en_q;
  assign halted    = halted_q;
  assign cause     = cause_q;
  assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Scenario bench for run_ctrl: expected output tuples are queued as stimulus is
// applied and compared against the DUT after the documented button latency.
module tb_run_ctrl;

  logic        clk;
  logic        rst;
  logic        go, step, pause, run_n;
  logic [15:0] n_cycles;
  logic        halt_req, bp_en;
  logic [31:0] bp_addr, pc;
  logic        cpu_en, halted;
  logic [2:0]  cause;
  logic [31:0] cycle_cnt;
  logic        cpu_en2, halted2;
  logic [2:0]  cause2;
  logic [7:0]  cycle_cnt2;

  run_ctrl #(.PC_W(32), .CNT_W(32), .START_RUN(1'b1)) dut (
    .clk(clk), .rst(rst), .go(go), .step(step), .pause(pause), .run_n(run_n),
    .n_cycles(n_cycles), .halt_req(halt_req), .bp_en(bp_en), .bp_addr(bp_addr),
    .pc(pc), .cpu_en(cpu_en), .halted(halted), .cause(cause), .cycle_cnt(cycle_cnt)
  );

  run_ctrl #(.PC_W(32), .CNT_W(8), .START_RUN(1'b0)) dut_halt (
    .clk(clk), .rst(rst), .go(go), .step(step), .pause(pause), .run_n(run_n),
    .n_cycles(n_cycles), .halt_req(halt_req), .bp_en(bp_en), .bp_addr(bp_addr),
    .pc(pc), .cpu_en(cpu_en2), .halted(halted2), .cause(cause2), .cycle_cnt(cycle_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [35:0] v;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  int          total = 0;
  int          bad   = 0;
  logic [35:0] obs;

  assign obs = {cpu_en, halted, cause, cycle_cnt};

  function automatic exp_t mk(string nm, bit en, bit h, logic [2:0] c, logic [31:0] cc);
    exp_t r;
    r.nm = nm;
    r.v  = {en, h, c, cc};
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    exp_q.push_back(mk("reset_state", 1'b1, 1'b0, 3'd0, 32'd0));
    e = exp_q.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.nm, obs, e.v); end
    total++;
    if ({cpu_en2, halted2, cause2, cycle_cnt2} !== {1'b0, 1'b1, 3'd0, 8'd0}) begin
      bad++;
      $display("FAIL reset_halt_variant: got %b%b %0d %0d want 0 1 0 0", cpu_en2, halted2, cause2, cycle_cnt2);
    end
    rst = 1'b0;
    exp_q.push_back(mk("ten_cycles", 1'b1, 1'b0, 3'd0, 32'd10));
    repeat (10) tick();
    e = exp_q.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.nm, obs, e.v); end
  endtask

  task automatic test_syscall();
    halt_req = 1'b1;
    exp_q.push_back(mk("syscall_halt", 1'b0, 1'b1, 3'd1, 32'd11));
    tick();
    e = exp_q.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.nm, obs, e.v); end
    go = 1'b1;
    exp_q.push_back(mk("syscall_resume", 1'b1, 1'b0, 3'd1, 32'd11));
    exp_q.push_back(mk("syscall_masked", 1'b1, 1'b0, 3'd1, 32'd12));
    exp_q.push_back(mk("syscall_rehalt", 1'b0, 1'b1, 3'd1, 32'd13));
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      e = exp_q.pop_front(); total++;
      if (obs !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.nm, obs, e.v); end
    end
    go = 1'b0;
    halt_req = 1'b0;
    exp_q.push_back(mk("syscall_held_go_once", 1'b0, 1'b1, 3'd1, 32'd13));
    repeat (4) tick();
    e = exp_q.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.nm, obs, e.v); end
  endtask

  task automatic test_breakpoint();
    bp_en   = 1'b1;
    bp_addr = 32'h0040_0010;
    pc      = 32'h0040_0000;
    go      = 1'b1;
    repeat (3) tick();
    go = 1'b0;
    exp_q.push_back(mk("bp_before_hit", 1'b1, 1'b0, 3'd1, 32'd17));
    exp_q.push_back(mk("bp_hit", 1'b0, 1'b1, 3'd2, 32'd18));
    for (int i = 0; i < 5; i++) begin
      pc = 32'h0040_0000 + 32'(i * 4);
      tick();
      if (i >= 3) begin
        e = exp_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.nm, obs, e.v); end
      end
    end
    go = 1'b1;
    exp_q.push_back(mk("bp_no_rehalt", 1'b1, 1'b0, 3'd2, 32'd23));
    repeat (3) tick();
    go = 1'b0;
    repeat (5) tick();
    e = exp_q.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.nm, obs, e.v); end
    pause = 1'b1;
    exp_q.push_back(mk("pause_halt", 1'b0, 1'b1, 3'd5, 32'd26));
    repeat (3) tick();
    pause = 1'b0;
    e = exp_q.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.nm, obs, e.v); end
    bp_en = 1'b0;
    pause = 1'b1;
    exp_q.push_back(mk("pause_in_halt_ignored", 1'b0, 1'b1, 3'd5, 32'd26));
    repeat (4) tick();
    pause = 1'b0;
    tick();
    e = exp_q.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.nm, obs, e.v); end
  endtask

  task automatic test_step();
    step = 1'b1;
    exp_q.push_back(mk("step_enabled", 1'b1, 1'b0, 3'd5, 32'd26));
    exp_q.push_back(mk("step_done", 1'b0, 1'b1, 3'd3, 32'd27));
    exp_q.push_back(mk("step_stays_halted", 1'b0, 1'b1, 3'd3, 32'd27));
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      e = exp_q.pop_front(); total++;
      if (obs !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.nm, obs, e.v); end
    end
    step = 1'b0;
    repeat (3) tick();
    step = 1'b1;
    go   = 1'b1;
    exp_q.push_back(mk("go_beats_step", 1'b1, 1'b0, 3'd3, 32'd29));
    repeat (5) tick();
    step = 1'b0;
    go   = 1'b0;
    e = exp_q.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.nm, obs, e.v); end
    pause = 1'b1;
    repeat (3) tick();
    pause = 1'b0;
    exp_q.push_back(mk("go_step_pause", 1'b0, 1'b1, 3'd5, 32'd32));
    e = exp_q.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.nm, obs, e.v); end
  endtask

  task automatic test_run_n();
    n_cycles = 16'd5;
    run_n    = 1'b1;
    exp_q.push_back(mk("run_n_start", 1'b1, 1'b0, 3'd5, 32'd32));
    exp_q.push_back(mk("run_n_cycle4", 1'b1, 1'b0, 3'd5, 32'd36));
    exp_q.push_back(mk("run_n_expire", 1'b0, 1'b1, 3'd4, 32'd37));
    repeat (3) tick();
    run_n = 1'b0;
    e = exp_q.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.nm, obs, e.v); end
    repeat (4) tick();
    e = exp_q.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.nm, obs, e.v); end
    tick();
    e = exp_q.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.nm, obs, e.v); end
    n_cycles = 16'd0;
    run_n    = 1'b1;
    exp_q.push_back(mk("run_n_zero", 1'b0, 1'b1, 3'd4, 32'd37));
    repeat (4) tick();
    run_n = 1'b0;
    e = exp_q.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.nm, obs, e.v); end
  endtask

  task automatic test_reset_mid_run_n();
    repeat (2) tick();
    n_cycles = 16'd8;
    run_n    = 1'b1;
    repeat (3) tick();
    run_n = 1'b0;
    exp_q.push_back(mk("mid_run_n_cycle1", 1'b1, 1'b0, 3'd4, 32'd38));
    tick();
    e = exp_q.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.nm, obs, e.v); end
    rst = 1'b1;
    exp_q.push_back(mk("mid_run_n_reset", 1'b1, 1'b0, 3'd0, 32'd0));
    tick();
    rst = 1'b0;
    e = exp_q.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.nm, obs, e.v); end
    exp_q.push_back(mk("no_count_after_reset", 1'b1, 1'b0, 3'd0, 32'd10));
    repeat (10) tick();
    e = exp_q.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.nm, obs, e.v); end
    pause = 1'b1;
    exp_q.push_back(mk("pause_after_reset", 1'b0, 1'b1, 3'd5, 32'd13));
    repeat (3) tick();
    pause = 1'b0;
    e = exp_q.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.nm, obs, e.v); end
  endtask

  initial begin
    rst      = 1'b1;
    go       = 1'b0;
    step     = 1'b0;
    pause    = 1'b0;
    run_n    = 1'b0;
    n_cycles = 16'd0;
    halt_req = 1'b0;
    bp_en    = 1'b0;
    bp_addr  = 32'd0;
    pc       = 32'd0;
    #1;
    test_reset();
    test_syscall();
    test_breakpoint();
    test_step();
    test_run_n();
    test_reset_mid_run_n();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
